// File: rtl/toggle_event_decoder.sv
// rtl/toggle_event_decoder.sv - toggle-link receiver: sync, edge-to-event, pending queue
module toggle_event_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4,
    parameter int TOT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tog_in,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [CNT_W-1:0] pend_cnt,
    output logic [TOT_W-1:0] total_cnt,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] PEND_MAX = {CNT_W{1'b1}};

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [CNT_W-1:0]       pend_q;
    logic [CNT_W-1:0]       pend_d;
    logic [TOT_W-1:0]       total_q;
    logic [TOT_W-1:0]       total_d;
    logic                   ovf_q;
    logic                   ovf_d;
    logic                   tog_edge;
    logic                   take;

    // Either level change of the synchronised toggle is one event; prev resets to the
    // sender's reset level so a high toggle at reset release decodes as one event.
    assign tog_edge = sync_q[SYNC_STAGES-1] ^ prev_q;
    assign ev_valid = (pend_q != '0);
    assign take     = ev_valid && ev_ready;

    // Synchroniser chain and previous-sample register for the possibly async toggle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tog_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Pending/total/overflow next state: an edge and a take in the same cycle cancel,
    // and an edge arriving at saturation with no take is dropped and flagged.
    always_comb begin
        pend_d  = pend_q;
        total_d = total_q;
        ovf_d   = ovf_q;
        if (tog_edge) begin
            total_d = total_q + 1'b1;
        end
        if (tog_edge && !take) begin
            if (pend_q == PEND_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + 1'b1;
            end
        end else if (!tog_edge && take) begin
            pend_d = pend_q - 1'b1;
        end
    end

    // Counter state registers; reset discards any pending events.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pend_q  <= '0;
            total_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            total_q <= total_d;
            ovf_q   <= ovf_d;
        end
    end

    assign pend_cnt  = pend_q;
    assign total_cnt = total_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_toggle_event_decoder.sv
// tb/tb_toggle_event_decoder.sv - scoreboard bench for toggle_event_decoder
module tb_toggle_event_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       tog_in;
    logic       ev_valid;
    logic       ev_ready;
    logic [3:0] pend_cnt;
    logic [7:0] total_cnt;
    logic       overflow;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        string      name;
        logic       v;
        logic [3:0] p;
        logic [7:0] t;
        logic       o;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    toggle_event_decoder #(.SYNC_STAGES(2), .CNT_W(4), .TOT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .tog_in    (tog_in),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .pend_cnt  (pend_cnt),
        .total_cnt (total_cnt),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: at each falling edge, compare every expectation scheduled for this cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (mon_e.cyc != cyc) begin
                errors++;
                $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)",
                         mon_e.name, mon_e.cyc, cyc);
            end else if (ev_valid !== mon_e.v || pend_cnt !== mon_e.p ||
                         total_cnt !== mon_e.t || overflow !== mon_e.o) begin
                errors++;
                $display("FAIL %s: got valid=%0b pend=%0d total=%0d ovf=%0b, want valid=%0b pend=%0d total=%0d ovf=%0b",
                         mon_e.name, ev_valid, pend_cnt, total_cnt, overflow,
                         mon_e.v, mon_e.p, mon_e.t, mon_e.o);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input string name, input logic v, input logic [3:0] p,
                              input logic [7:0] t, input logic o);
        exp_t e;
        e.cyc  = cyc;
        e.name = name;
        e.v    = v;
        e.p    = p;
        e.t    = t;
        e.o    = o;
        exp_q.push_back(e);
    endtask

    task automatic toggles(input int n);
        for (int i = 0; i < n; i++) begin
            tog_in = ~tog_in;
            step(1);
        end
    endtask

    initial begin
        reset    = 1'b0;
        tog_in   = 1'b0;
        ev_ready = 1'b0;

        // 1: reset and idle
        step(4);
        expect_now("reset_state", 1'b0, 4'd0, 8'd0, 1'b0);
        reset = 1'b1;
        step(10);
        expect_now("idle_after_reset", 1'b0, 4'd0, 8'd0, 1'b0);

        // 2: single event, latency of two edges after capture
        tog_in = 1'b1;
        step(1);
        expect_now("single_capture", 1'b0, 4'd0, 8'd0, 1'b0);
        step(1);
        expect_now("single_not_yet", 1'b0, 4'd0, 8'd0, 1'b0);
        step(1);
        expect_now("single_valid", 1'b1, 4'd1, 8'd1, 1'b0);
        ev_ready = 1'b1;
        step(1);
        ev_ready = 1'b0;
        expect_now("single_taken", 1'b0, 4'd0, 8'd1, 1'b0);

        // 3: five back-to-back toggles (both polarities), then drain
        toggles(5);
        step(3);
        expect_now("burst_pending", 1'b1, 4'd5, 8'd6, 1'b0);
        ev_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step(1);
            expect_now($sformatf("burst_take%0d", k), (k != 5), 4'(5 - k), 8'd6, 1'b0);
        end
        step(2);
        expect_now("ready_while_empty", 1'b0, 4'd0, 8'd6, 1'b0);
        ev_ready = 1'b0;

        // 4: edge and take in the same cycle keep pend_cnt unchanged
        toggles(3);
        step(3);
        expect_now("simul_pend3", 1'b1, 4'd3, 8'd9, 1'b0);
        tog_in = ~tog_in;
        step(1);
        expect_now("simul_still3", 1'b1, 4'd3, 8'd9, 1'b0);
        ev_ready = 1'b1;
        step(1);
        expect_now("simul_2a", 1'b1, 4'd2, 8'd9, 1'b0);
        step(1);
        expect_now("simul_2b", 1'b1, 4'd2, 8'd10, 1'b0);
        step(1);
        expect_now("simul_1", 1'b1, 4'd1, 8'd10, 1'b0);
        step(1);
        expect_now("simul_0", 1'b0, 4'd0, 8'd10, 1'b0);
        ev_ready = 1'b0;

        // 5: saturation, sticky overflow, total wrap
        toggles(17);
        step(3);
        expect_now("sat_full", 1'b1, 4'd15, 8'd27, 1'b1);
        ev_ready = 1'b1;
        step(15);
        ev_ready = 1'b0;
        expect_now("sat_drained", 1'b0, 4'd0, 8'd27, 1'b1);
        toggles(256);
        step(3);
        expect_now("total_wrap", 1'b1, 4'd15, 8'd27, 1'b1);

        // 6: reset mid-operation with pending events
        ev_ready = 1'b1;
        step(9);
        ev_ready = 1'b0;
        expect_now("pend6", 1'b1, 4'd6, 8'd27, 1'b1);
        reset = 1'b0;
        step(1);
        expect_now("midop_reset", 1'b0, 4'd0, 8'd0, 1'b0);
        reset  = 1'b1;
        tog_in = 1'b1;
        step(2);
        expect_now("post_reset_wait", 1'b0, 4'd0, 8'd0, 1'b0);
        step(1);
        expect_now("post_reset_event", 1'b1, 4'd1, 8'd1, 1'b0);

        // Let the monitor consume everything, bounded.
        for (int w = 0; w < 20 && exp_q.size() > 0; w++) step(1);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain_scoreboard: %0d expectations left, want 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
